// File: rtl/dmem_bridge_if.sv
// CPU data-memory port and system bus bundled for dmem_bridge.
// master = the bridge itself, slave = the CPU/memory environment around it.
interface dmem_bridge_if;
    logic        cpu_memread;
    logic        cpu_memwrite;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        err;
    logic        err_clr;

    modport master (
        input  cpu_memread, cpu_memwrite, cpu_addr, cpu_wdata, bus_ack, bus_rdata, err_clr,
        output cpu_rdata, cpu_stall, bus_req, bus_we, bus_addr, bus_wdata, err
    );

    modport slave (
        output cpu_memread, cpu_memwrite, cpu_addr, cpu_wdata, bus_ack, bus_rdata, err_clr,
        input  cpu_rdata, cpu_stall, bus_req, bus_we, bus_addr, bus_wdata, err
    );
endinterface

// File: rtl/dmem_bridge.sv
// Bridges a single-issue CPU MEM stage onto a req/ack bus, stalling the pipeline meanwhile.
// Define DMEM_BRIDGE_TIMEOUT_EN to abort bus accesses that never see bus_ack.
module dmem_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input logic           clk,
    input logic           reset,
    dmem_bridge_if.master dif
);

    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("dmem_bridge: TIMEOUT_CYCLES must be in 2..255");
    end

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e      state_q;
    logic        req_q;
    logic        we_q;
    logic [31:2] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        access;
    logic        aligned;
    logic        timeout_hit;
    logic        err_set;
    logic [31:0] busy_rdata;

    assign access  = dif.cpu_memread | dif.cpu_memwrite;
    assign aligned = (dif.cpu_addr[1:0] == 2'b00);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] tmo_q;

    // Counter holds the number of ack-less BUSY cycles already spent.
    assign timeout_hit = (state_q == StBusy) && !dif.bus_ack && (tmo_q == TmoLast);
`else
    assign timeout_hit = 1'b0;
`endif

    assign err_set    = ((state_q == StIdle) && access && !aligned) || timeout_hit;
    assign busy_rdata = dif.bus_ack ? dif.bus_rdata : ERR_RDATA;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            // Set beats a same-cycle clear.
            if (err_set) begin
                err_q <= 1'b1;
            end else if (dif.err_clr) begin
                err_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (access) begin
                        if (aligned) begin
                            we_q    <= dif.cpu_memwrite;
                            addr_q  <= dif.cpu_addr[31:2];
                            wdata_q <= dif.cpu_wdata;
                            req_q   <= 1'b1;
                            state_q <= StBusy;
`ifdef DMEM_BRIDGE_TIMEOUT_EN
                            tmo_q   <= '0;
`endif
                        end else begin
                            if (!dif.cpu_memwrite) begin
                                rdata_q <= '0;
                            end
                            state_q <= StDone;
                        end
                    end
                end
                StBusy: begin
                    if (dif.bus_ack || timeout_hit) begin
                        req_q   <= 1'b0;
                        if (!we_q) begin
                            rdata_q <= busy_rdata;
                        end
                        state_q <= StDone;
                    end
`ifdef DMEM_BRIDGE_TIMEOUT_EN
                    else begin
                        tmo_q <= tmo_q + 8'd1;
                    end
`endif
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Stall must rise in the same cycle the access appears, hence combinational.
    assign dif.cpu_stall = reset && (((state_q == StIdle) && access) || (state_q == StBusy));
    assign dif.cpu_rdata = rdata_q;
    assign dif.bus_req   = req_q;
    assign dif.bus_we    = we_q;
    assign dif.bus_addr  = {addr_q, 2'b00};
    assign dif.bus_wdata = wdata_q;
    assign dif.err       = err_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Randomized scoreboard bench for dmem_bridge: stimulus pushes expected results,
// a forked monitor pops and compares them whenever an access completes.
module tb_dmem_bridge;
    localparam int unsigned TIMEOUT_CYCLES = 16;
    localparam logic [31:0] ERR_RDATA      = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    dmem_bridge_if dif();

    dmem_bridge #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .ERR_RDATA     (ERR_RDATA)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .dif  (dif)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stalls;
        int          bus_cycles;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    bit          mon_en = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        m_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    task automatic monitor();
        int   stall_cnt = 0;
        int   bus_cnt = 0;
        exp_t e;
        logic acc;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                stall_cnt = 0;
                bus_cnt = 0;
            end else begin
                acc = dif.cpu_memread | dif.cpu_memwrite;
                if (dif.bus_req) begin
                    bus_cnt++;
                    if (exp_q.size() == 0) begin
                        fail_now("bus_req_spurious");
                    end else begin
                        chk("bus_we", {31'b0, dif.bus_we}, {31'b0, exp_q[0].we});
                        chk("bus_addr", dif.bus_addr, exp_q[0].addr);
                        if (exp_q[0].we) chk("bus_wdata", dif.bus_wdata, exp_q[0].wdata);
                    end
                end
                if (dif.cpu_stall) begin
                    stall_cnt++;
                    if (!acc) fail_now("stall_without_access");
                end else if (acc) begin
                    if (exp_q.size() == 0) begin
                        fail_now("completion_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        chk("cpu_rdata", dif.cpu_rdata, e.rdata);
                        chk("err", {31'b0, dif.err}, {31'b0, e.err});
                        chk("stall_cycles", stall_cnt, e.stalls);
                        chk("bus_cycles", bus_cnt, e.bus_cycles);
                    end
                    stall_cnt = 0;
                    bus_cnt = 0;
                end
            end
        end
    endtask

    task automatic drive_idle_inputs();
        dif.cpu_memread  = 1'b0;
        dif.cpu_memwrite = 1'b0;
        dif.cpu_addr     = $urandom;
        dif.cpu_wdata    = $urandom;
        dif.bus_ack      = 1'b0;
        dif.bus_rdata    = $urandom;
        dif.err_clr      = 1'b0;
    endtask

    // One CPU access; waits = extra bus wait cycles before the ack pulse.
    task automatic access(input bit rd, input bit wr, input logic [31:0] a,
                          input logic [31:0] wd, input int waits, input logic [31:0] brd,
                          input bit clr);
        exp_t e;
        bit   ok;
        ok = (a[1:0] == 2'b00);
        if (!ok) begin
            m_err = 1'b1;
            if (!wr) m_rdata = '0;
            e.stalls = 1;
            e.bus_cycles = 0;
        end else begin
            if (clr) m_err = 1'b0;
            if (!wr) m_rdata = brd;
            e.stalls = 2 + waits;
            e.bus_cycles = waits + 1;
        end
        e.rdata = m_rdata;
        e.err   = m_err;
        e.we    = wr;
        e.addr  = a;
        e.wdata = wd;
        exp_q.push_back(e);

        dif.cpu_memread  = rd;
        dif.cpu_memwrite = wr;
        dif.cpu_addr     = a;
        dif.cpu_wdata    = wd;
        dif.err_clr      = clr;
        @(posedge clk); #1;
        dif.err_clr = 1'b0;
        if (ok) begin
            repeat (waits) begin
                @(posedge clk); #1;
            end
            dif.bus_ack   = 1'b1;
            dif.bus_rdata = brd;
            @(posedge clk); #1;
            dif.bus_ack   = 1'b0;
            dif.bus_rdata = $urandom;
        end
        @(posedge clk); #1;
        drive_idle_inputs();
    endtask

    task automatic idle(input int n, input bit clr, input bit stray_ack);
        for (int i = 0; i < n; i++) begin
            dif.err_clr   = clr && (i == 0);
            dif.bus_ack   = stray_ack;
            dif.bus_rdata = $urandom;
            if (clr && i == 0) m_err = 1'b0;
            @(posedge clk); #1;
            dif.err_clr = 1'b0;
            dif.bus_ack = 1'b0;
        end
    endtask

    initial begin
        bit          rd;
        bit          wr;
        int          k;
        logic [31:0] a;

        drive_idle_inputs();
        dif.cpu_memread = 1'b1;
        dif.cpu_addr    = 32'h0000_0010;
        fork
            monitor();
        join_none

        // Reset state, with a pending load held on the CPU side.
        #3;
        chk("rst_cpu_stall", {31'b0, dif.cpu_stall}, 32'h0);
        chk("rst_bus_req", {31'b0, dif.bus_req}, 32'h0);
        chk("rst_bus_we", {31'b0, dif.bus_we}, 32'h0);
        chk("rst_bus_addr", dif.bus_addr, 32'h0);
        chk("rst_bus_wdata", dif.bus_wdata, 32'h0);
        chk("rst_cpu_rdata", dif.cpu_rdata, 32'h0);
        chk("rst_err", {31'b0, dif.err}, 32'h0);
        dif.cpu_memread = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Directed scenarios.
        access(1'b1, 1'b0, 32'h0000_0010, 32'h0, 0, 32'h1234_5678, 1'b0);
        access(1'b0, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 3, 32'h5555_AAAA, 1'b0);
        access(1'b1, 1'b0, 32'h0000_0013, 32'h0, 0, 32'h0, 1'b0);
        idle(1, 1'b1, 1'b0);
        chk("err_after_clr", {31'b0, dif.err}, 32'h0);
        access(1'b1, 1'b1, 32'h0000_0040, 32'h0BAD_F00D, 1, 32'h7777_7777, 1'b0);
        access(1'b0, 1'b1, 32'h0000_0051, 32'h1, 0, 32'h0, 1'b1);
        idle(2, 1'b0, 1'b1);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
        begin
            exp_t e;
            m_err = 1'b1;
            m_rdata = ERR_RDATA;
            e.rdata = m_rdata;
            e.err = 1'b1;
            e.stalls = 1 + TIMEOUT_CYCLES;
            e.bus_cycles = TIMEOUT_CYCLES;
            e.we = 1'b0;
            e.addr = 32'h0000_0080;
            e.wdata = 32'h0;
            exp_q.push_back(e);
            dif.cpu_memread = 1'b1;
            dif.cpu_addr = 32'h0000_0080;
            repeat (TIMEOUT_CYCLES + 2) begin
                @(posedge clk); #1;
            end
            drive_idle_inputs();
            idle(1, 1'b1, 1'b0);
        end
`endif

        // Reset asserted in the 2nd BUSY cycle, late ack after release.
        mon_en = 1'b0;
        dif.cpu_memread = 1'b1;
        dif.cpu_addr = 32'h0000_0100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("midrst_bus_req", {31'b0, dif.bus_req}, 32'h0);
        chk("midrst_cpu_stall", {31'b0, dif.cpu_stall}, 32'h0);
        dif.cpu_memread = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        dif.bus_ack = 1'b1;
        dif.bus_rdata = 32'hFEED_FACE;
        @(posedge clk); #1;
        dif.bus_ack = 1'b0;
        chk("late_ack_bus_req", {31'b0, dif.bus_req}, 32'h0);
        chk("late_ack_cpu_stall", {31'b0, dif.cpu_stall}, 32'h0);
        chk("late_ack_cpu_rdata", dif.cpu_rdata, 32'h0);
        chk("late_ack_err", {31'b0, dif.err}, 32'h0);
        m_rdata = '0;
        m_err = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 2);
            rd = (k != 1);
            wr = (k != 0);
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            access(rd, wr, a, $urandom, $urandom_range(0, 6), $urandom,
                   ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 2) == 0) begin
                idle($urandom_range(1, 3), ($urandom_range(0, 4) == 0),
                     ($urandom_range(0, 1) == 1));
            end
        end

        idle(3, 1'b0, 1'b0);
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
